bert_tx_lane_sequencer: RTL
===========================

Name: bert_tx_lane_sequencer

Overview:
- Downstream consumer of the BERT APB config block's TX config fields and its config_updated strobe.
- Turns static config into correctly sequenced transceiver control-pin activity:
  - full TX reset on clock-source change or software reset request;
  - TXRATE handshake on clock-divide change;
  - registered pass-through of PRBS, polarity and enable.
- Reports busy, lane-ready and timeout status for readback.

Parameters:
RESET_CYCLES, 16, cycles gt_gttxreset is held high per reset pulse (minimum 1)
TIMEOUT_CYCLES, 65536, cycles allowed in any wait state before timeout and retry
RETRY_LIMIT, 3, consecutive timeouts before parking in FAULT

Ports:
clk  input  1  single clock; all logic synchronous to it
rst  input  1  asynchronous, active-high reset
config_updated  input  1  one-cycle strobe: cfg_* inputs changed
cfg_enable  input  1  TX output enable
cfg_invert  input  1  TX polarity invert
cfg_prbsmode  input  3  PRBS pattern select
cfg_clkdiv  input  3  TX rate divider
cfg_clk_from_qpll  input  1  1=QPLL, 0=CPLL
cfg_tx_reset  input  1  software reset level
gt_cpll_lock  input  1  CPLL lock (already synchronized)
gt_qpll_lock  input  1  QPLL lock (already synchronized)
gt_txresetdone  input  1  GT reset-done (already synchronized)
gt_txratedone  input  1  one-cycle rate-change-done pulse
gt_gttxreset  output  1  GT full TX reset
gt_txuserrdy  output  1  user clock ready to GT
gt_txrate  output  3  applied rate divider
gt_txsysclksel  output  2  11 = QPLL, 00 = CPLL
gt_txpllclksel  output  2  11 = QPLL, 00 = CPLL
gt_txprbssel  output  3  registered cfg_prbsmode
gt_txpolarity  output  1  registered cfg_invert
gt_txinhibit  output  1  1 unless enabled and in RUN
busy  output  1  1 whenever state != RUN
lane_ready  output  1  1 in RUN only
timeout_err  output  1  sticky; cleared by next config_updated

Behaviour:
Reset (rst high):
- state=RESET_ASSERT, counters=0, retry count=0, pending=0.
- Applied clkdiv=0, applied clk_from_qpll=0.
- Output values: gt_gttxreset=1, gt_txuserrdy=0, gt_txrate=0, sel outputs=00, prbssel=0, polarity=0, txinhibit=1, busy=1, lane_ready=0, timeout_err=0.
- Reset mid-sequence aborts immediately to these values.

Pass-through:
- gt_txprbssel and gt_txpolarity track cfg_* with 1-cycle latency in every state, FAULT included.
- gt_txinhibit = ~cfg_enable_q | (state != RUN), registered.

States:
- RESET_ASSERT:
  - gt_gttxreset=1, gt_txuserrdy=0.
  - Count RESET_CYCLES, also stay while cfg_tx_reset=1, then go to WAIT_LOCK.
  - Sel outputs update from the applied source on entry.
- WAIT_LOCK: gt_gttxreset=0. Wait for the lock of the selected PLL, then go to WAIT_DONE.
- WAIT_DONE: gt_txuserrdy=1. Wait for gt_txresetdone=1, then RUN and clear retry count.
- RUN:
  - lane_ready=1.
  - On config_updated, or pending=1, evaluate in priority order:
    1. cfg_tx_reset=1 or cfg_clk_from_qpll != applied: latch both cfg_clkdiv and cfg_clk_from_qpll as applied, go to RESET_ASSERT.
    2. cfg_clkdiv != applied: latch it, drive gt_txrate, go to WAIT_RATE.
    3. Otherwise stay in RUN.
  - Clear pending.
- WAIT_RATE: wait for gt_txratedone, then RUN. A txratedone pulse in any other state is ignored.
- FAULT:
  - gt_gttxreset=1, busy=1.
  - Left only via config_updated, which goes to RESET_ASSERT with retry count cleared.

Timeout:
- A shared counter clears on entry to WAIT_LOCK, WAIT_DONE and WAIT_RATE.
- At TIMEOUT_CYCLES-1 without the awaited event:
  - timeout_err<=1, retry++, go to RESET_ASSERT;
  - if retry reaches RETRY_LIMIT, go to FAULT instead.
- Counter saturates and does not wrap.

Simultaneous and boundary events:
- config_updated while not in RUN sets pending; it is evaluated on the first RUN cycle.
- config_updated clears timeout_err in the same cycle. If a timeout fires in that same cycle, the set wins.
- Lock is level-sampled: loss of lock during RUN is not monitored; software recovers by reset.
- A lock or done already high on wait-state entry advances the state on the next cycle. Minimum reset-to-RUN time is RESET_CYCLES+2 cycles.

Test Plan:
1. Power-up, RESET_CYCLES=16, cpll_lock=1, txresetdone tied 1: gt_gttxreset high exactly 16 cycles; lane_ready=1 by cycle 18; gt_txsysclksel=00.
2. In RUN, strobe with prbsmode=5, invert=1, enable=1, source/div unchanged: prbssel=5, polarity=1, txinhibit=0 one cycle later; busy stays 0.
3. Strobe with clkdiv 0→2: gt_txrate=2, busy=1 until txratedone pulse injected 40 cycles later; no gt_gttxreset.
4. Strobe with clk_from_qpll=1, qpll_lock held 0 for 200 cycles then 1: sel outputs=11, reset pulse, WAIT_LOCK holds 200 cycles, then RUN.
5. TIMEOUT_CYCLES=64, txresetdone stuck 0: timeout_err=1 after 64 cycles; three retries then FAULT; a config_updated strobe clears timeout_err and restarts the sequence.
6. Assert rst during WAIT_RATE; also strobe config_updated during WAIT_DONE: all outputs return to reset values; pending strobe evaluated on the first RUN cycle.

Source files
------------

// File: rtl/bert_tx_lane_sequencer.sv
// Sequences GT transceiver TX control pins from static BERT config: full TX reset on source
// change or software request, TXRATE handshake on divider change, timeout/retry supervision.
module bert_tx_lane_sequencer #(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned RETRY_LIMIT    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       config_updated,
  input  logic       cfg_enable,
  input  logic       cfg_invert,
  input  logic [2:0] cfg_prbsmode,
  input  logic [2:0] cfg_clkdiv,
  input  logic       cfg_clk_from_qpll,
  input  logic       cfg_tx_reset,
  input  logic       gt_cpll_lock,
  input  logic       gt_qpll_lock,
  input  logic       gt_txresetdone,
  input  logic       gt_txratedone,
  output logic       gt_gttxreset,
  output logic       gt_txuserrdy,
  output logic [2:0] gt_txrate,
  output logic [1:0] gt_txsysclksel,
  output logic [1:0] gt_txpllclksel,
  output logic [2:0] gt_txprbssel,
  output logic       gt_txpolarity,
  output logic       gt_txinhibit,
  output logic       busy,
  output logic       lane_ready,
  output logic       timeout_err
);

  localparam int unsigned CntMax = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES
                                                                   : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned RetryW = $clog2(RETRY_LIMIT + 1);

  localparam logic [CntW-1:0]   ResetLast   = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    StResetAssert,
    StWaitLock,
    StWaitDone,
    StRun,
    StWaitRate,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              pending_q, pending_d;
  logic [2:0]        clkdiv_q, clkdiv_d;
  logic              src_q, src_d;
  logic              timeout_q, timeout_d;
  logic [1:0]        sel_q;
  logic              pll_lock;
  logic              timeout_hit;

  assign pll_lock    = src_q ? gt_qpll_lock : gt_cpll_lock;
  assign gt_txrate   = clkdiv_q;
  assign timeout_err = timeout_q;

  assign gt_txsysclksel = sel_q;
  assign gt_txpllclksel = sel_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    pending_d   = pending_q;
    clkdiv_d    = clkdiv_q;
    src_d       = src_q;
    timeout_d   = timeout_q;
    timeout_hit = 1'b0;

    if (config_updated) begin
      timeout_d = 1'b0;
      if (state_q != StRun) pending_d = 1'b1;
    end

    unique case (state_q)
      StResetAssert: begin
        if (cnt_q == ResetLast) begin
          if (!cfg_tx_reset) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (pll_lock) begin
          state_d = StWaitDone;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (gt_txresetdone) begin
          state_d = StRun;
          retry_d = '0;
        end else if (cnt_q == TimeoutLast) begin
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (config_updated || pending_q) begin
          pending_d = 1'b0;
          if (cfg_tx_reset || (cfg_clk_from_qpll != src_q)) begin
            src_d    = cfg_clk_from_qpll;
            clkdiv_d = cfg_clkdiv;
            state_d  = StResetAssert;
            cnt_d    = '0;
          end else if (cfg_clkdiv != clkdiv_q) begin
            clkdiv_d = cfg_clkdiv;
            state_d  = StWaitRate;
            cnt_d    = '0;
          end
        end
      end
      StWaitRate: begin
        if (gt_txratedone) begin
          state_d = StRun;
        end else if (cnt_q == TimeoutLast) begin
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFault: begin
        if (config_updated) begin
          state_d = StResetAssert;
          retry_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StResetAssert;
        cnt_d   = '0;
      end
    endcase

    // Applied after the strobe clear so a coincident timeout still gets reported.
    if (timeout_hit) begin
      timeout_d = 1'b1;
      retry_d   = retry_q + 1'b1;
      cnt_d     = '0;
      state_d   = (retry_d == RetryMax) ? StFault : StResetAssert;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StResetAssert;
      cnt_q         <= '0;
      retry_q       <= '0;
      pending_q     <= 1'b0;
      clkdiv_q      <= 3'd0;
      src_q         <= 1'b0;
      timeout_q     <= 1'b0;
      sel_q         <= 2'b00;
      gt_gttxreset  <= 1'b1;
      gt_txuserrdy  <= 1'b0;
      gt_txprbssel  <= 3'd0;
      gt_txpolarity <= 1'b0;
      gt_txinhibit  <= 1'b1;
      busy          <= 1'b1;
      lane_ready    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pending_q     <= pending_d;
      clkdiv_q      <= clkdiv_d;
      src_q         <= src_d;
      timeout_q     <= timeout_d;
      if (state_d == StResetAssert) sel_q <= {2{src_d}};
      gt_gttxreset  <= (state_d == StResetAssert) || (state_d == StFault);
      gt_txuserrdy  <= state_d inside {StWaitDone, StRun, StWaitRate};
      gt_txprbssel  <= cfg_prbsmode;
      gt_txpolarity <= cfg_invert;
      gt_txinhibit  <= !cfg_enable || (state_d != StRun);
      busy          <= state_d != StRun;
      lane_ready    <= state_d == StRun;
    end
  end

endmodule
